// File: rtl/nim_trig_pkg.sv
// Shared types and field widths for the NIM trigger-decision controller.
package nim_trig_pkg;

    localparam int unsigned PRESCALE_W = 16;
    localparam int unsigned DEADTIME_W = 16;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARMED    = 2'd1,
        WAIT_ACK = 2'd2,
        DEADTIME = 2'd3
    } trig_state_t;

endpackage

// File: rtl/nim_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over a same-cycle increment.
module nim_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/nim_trigger_ctrl.sv
// Coincidence/edge/prescale trigger decision with DAQ busy-ack handshake, deadtime and
// accepted/vetoed edge counters.
module nim_trigger_ctrl
    import nim_trig_pkg::*;
#(
    parameter int unsigned N_CHAN      = 8,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned ACK_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_enable,
    input  logic                  cnt_clear,
    input  logic [N_CHAN-1:0]     chan_trig,
    input  logic [N_CHAN-1:0]     coinc_mask,
    input  logic                  coinc_and,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [DEADTIME_W-1:0] deadtime,
    input  logic                  daq_ack,
    output logic                  trig_accept,
    output logic                  trig_busy,
    output logic [CNT_W-1:0]      trig_count,
    output logic [CNT_W-1:0]      veto_count,
    output logic                  timeout_flag
);

    localparam int unsigned WT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [WT_W-1:0] WT_LAST = WT_W'(ACK_TIMEOUT - 1);

    trig_state_t           state;
    logic                  comb_c;
    logic                  comb_q;
    logic                  comb_qq;
    logic                  rise_c;
    logic                  pre_hit_c;
    logic                  trig_inc_c;
    logic                  veto_inc_c;
    logic                  ack_ok_c;
    logic                  wait_done_c;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic [DEADTIME_W-1:0] dt_cnt;
    logic [WT_W-1:0]       wt_cnt;

    // An empty mask never fires, even in AND mode where the reduction would be vacuously true.
    assign comb_c = (|coinc_mask) &
                    (coinc_and ? (&(chan_trig | ~coinc_mask)) : (|(chan_trig & coinc_mask)));

    assign rise_c      = comb_q & ~comb_qq;
    // >= keeps a lowered prescale from stranding the counter above the new threshold.
    assign pre_hit_c   = (pre_cnt >= prescale);
    assign trig_inc_c  = run_enable && (state == ARMED) && rise_c && pre_hit_c;
    assign veto_inc_c  = run_enable && rise_c && ((state == WAIT_ACK) || (state == DEADTIME));
    assign ack_ok_c    = daq_ack && !trig_accept;
    assign wait_done_c = ack_ok_c || (wt_cnt == WT_LAST);

    // Combine/edge pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            comb_q  <= 1'b0;
            comb_qq <= 1'b0;
        end else begin
            comb_q  <= comb_c;
            comb_qq <= comb_q;
        end
    end

    // Trigger FSM with prescale, ack-timeout and deadtime counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= DISABLED;
            trig_accept  <= 1'b0;
            trig_busy    <= 1'b1;
            pre_cnt      <= '0;
            dt_cnt       <= '0;
            wt_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            trig_accept <= 1'b0;
            if (!run_enable) begin
                state     <= DISABLED;
                trig_busy <= 1'b1;
            end else begin
                case (state)
                    DISABLED: begin
                        state     <= ARMED;
                        trig_busy <= 1'b0;
                        pre_cnt   <= '0;
                    end
                    ARMED: begin
                        if (rise_c) begin
                            if (pre_hit_c) begin
                                trig_accept <= 1'b1;
                                trig_busy   <= 1'b1;
                                pre_cnt     <= '0;
                                wt_cnt      <= '0;
                                state       <= WAIT_ACK;
                            end else begin
                                pre_cnt <= pre_cnt + PRESCALE_W'(1);
                            end
                        end
                    end
                    WAIT_ACK: begin
                        if (wait_done_c) begin
                            if (!ack_ok_c) begin
                                timeout_flag <= 1'b1;
                            end
                            dt_cnt <= deadtime;
                            if (deadtime == '0) begin
                                state     <= ARMED;
                                trig_busy <= 1'b0;
                            end else begin
                                state <= DEADTIME;
                            end
                        end else begin
                            wt_cnt <= wt_cnt + WT_W'(1);
                        end
                    end
                    DEADTIME: begin
                        dt_cnt <= dt_cnt - DEADTIME_W'(1);
                        if (dt_cnt <= DEADTIME_W'(1)) begin
                            state     <= ARMED;
                            trig_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= DISABLED;
                        trig_busy <= 1'b1;
                    end
                endcase
            end
            if (cnt_clear) begin
                timeout_flag <= 1'b0;
            end
        end
    end

    nim_sat_counter #(.CNT_W(CNT_W)) u_trig_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (trig_inc_c),
        .clr   (cnt_clear),
        .count (trig_count)
    );

    nim_sat_counter #(.CNT_W(CNT_W)) u_veto_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (veto_inc_c),
        .clr   (cnt_clear),
        .count (veto_count)
    );

endmodule

// File: tb/tb_nim_trigger_ctrl.sv
// Randomized scoreboard bench for nim_trigger_ctrl against a timeline-based reference model.
module tb_nim_trigger_ctrl;

    localparam int unsigned N_CHAN  = 8;
    localparam int unsigned CNT_W   = 5;
    localparam int          ACK_T   = 16;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              run_enable;
    logic              cnt_clear;
    logic [N_CHAN-1:0] chan_trig;
    logic [N_CHAN-1:0] coinc_mask;
    logic              coinc_and;
    logic [15:0]       prescale;
    logic [15:0]       deadtime;
    logic              daq_ack;
    logic              trig_accept;
    logic              trig_busy;
    logic [CNT_W-1:0]  trig_count;
    logic [CNT_W-1:0]  veto_count;
    logic              timeout_flag;

    nim_trigger_ctrl #(.N_CHAN(N_CHAN), .CNT_W(CNT_W), .ACK_TIMEOUT(ACK_T)) dut (
        .clk          (clk),
        .reset        (reset),
        .run_enable   (run_enable),
        .cnt_clear    (cnt_clear),
        .chan_trig    (chan_trig),
        .coinc_mask   (coinc_mask),
        .coinc_and    (coinc_and),
        .prescale     (prescale),
        .deadtime     (deadtime),
        .daq_ack      (daq_ack),
        .trig_accept  (trig_accept),
        .trig_busy    (trig_busy),
        .trig_count   (trig_count),
        .veto_count   (veto_count),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit acc;
        bit busy;
        int tc;
        int vc;
        bit tf;
    } status_t;

    typedef struct {
        int cyc;
        int tc;
    } acc_t;

    status_t status_q[$];
    acc_t    acc_q[$];
    int      total = 0;
    int      bad   = 0;
    bit      mon_en = 1'b0;
    int      mcyc  = 0;

    // Reference model: cycle index, disabled flag, ack-wait window and re-arm time.
    int mc;
    bit m_dis;
    bit m_wait;
    bit m_acc;
    int m_wstart;
    int m_armed_from;
    int m_qual;
    bit cm1;
    bit cm2;
    int m_tc;
    int m_vc;
    bit m_tf;

    function automatic bit coinc(input logic [N_CHAN-1:0] ch, input logic [N_CHAN-1:0] mk,
                                 input logic and_m);
        int used = 0;
        int hit  = 0;
        for (int i = 0; i < int'(N_CHAN); i++) begin
            if (mk[i]) begin
                used++;
                if (ch[i]) hit++;
            end
        end
        if (used == 0) return 1'b0;
        return and_m ? (hit == used) : (hit > 0);
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_status();
        status_t s;
        s.cyc  = mc;
        s.acc  = m_acc;
        s.busy = m_dis || m_wait || (mc < m_armed_from);
        s.tc   = m_tc;
        s.vc   = m_vc;
        s.tf   = m_tf;
        status_q.push_back(s);
    endtask

    task automatic model_reset();
        mc = 0; m_dis = 1'b1; m_wait = 1'b0; m_acc = 1'b0; m_wstart = 0;
        m_armed_from = 0; m_qual = 0; cm1 = 1'b0; cm2 = 1'b0;
        m_tc = 0; m_vc = 0; m_tf = 1'b0;
        push_status();
    endtask

    // Consumes this cycle's inputs and predicts the outputs of the next cycle.
    task automatic model_step();
        bit rise;
        bit ack_ok;
        bit n_dis;
        bit n_acc;
        bit n_tf;
        int n_tc;
        int n_vc;
        rise  = cm1 && !cm2;
        n_dis = m_dis;
        n_acc = 1'b0;
        n_tc  = m_tc;
        n_vc  = m_vc;
        n_tf  = m_tf;
        if (!run_enable) begin
            n_dis = 1'b1; m_wait = 1'b0; m_armed_from = 0;
        end else if (m_dis) begin
            n_dis = 1'b0; m_qual = 0; m_armed_from = 0; m_wait = 1'b0;
        end else if (m_wait) begin
            ack_ok = daq_ack && (mc > m_wstart);
            if (rise) n_vc = sat_inc(m_vc);
            if (ack_ok || (mc == m_wstart + ACK_T - 1)) begin
                if (!ack_ok) n_tf = 1'b1;
                m_wait = 1'b0;
                m_armed_from = mc + 1 + int'(deadtime);
            end
        end else if (mc < m_armed_from) begin
            if (rise) n_vc = sat_inc(m_vc);
        end else if (rise) begin
            m_qual++;
            if (m_qual == int'(prescale) + 1) begin
                m_qual = 0; n_acc = 1'b1; m_wait = 1'b1; m_wstart = mc + 1;
                n_tc = sat_inc(m_tc);
            end
        end
        if (cnt_clear) begin
            n_tc = 0; n_vc = 0; n_tf = 1'b0;
        end
        if (n_acc) acc_q.push_back('{mc + 1, n_tc});
        cm2 = cm1;
        cm1 = coinc(chan_trig, coinc_mask, coinc_and);
        m_dis = n_dis; m_acc = n_acc; m_tc = n_tc; m_vc = n_vc; m_tf = n_tf;
        mc++;
        push_status();
    endtask

    // Monitor: per-cycle status check plus accept-queue pop whenever the DUT fires.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (status_q.size() == 0) begin
                bad++;
                $display("FAIL status_underflow: cycle %0d has no expectation", mcyc);
            end else begin
                status_t e;
                e = status_q.pop_front();
                if ((trig_accept !== e.acc) || (trig_busy !== e.busy) ||
                    (int'(trig_count) != e.tc) || (int'(veto_count) != e.vc) ||
                    (timeout_flag !== e.tf)) begin
                    bad++;
                    $display("FAIL status cyc=%0d got acc=%0b busy=%0b tc=%0d vc=%0d tf=%0b want acc=%0b busy=%0b tc=%0d vc=%0d tf=%0b",
                             mcyc, trig_accept, trig_busy, trig_count, veto_count, timeout_flag,
                             e.acc, e.busy, e.tc, e.vc, e.tf);
                end
            end
            if (trig_accept === 1'b1) begin
                total++;
                if (acc_q.size() == 0) begin
                    bad++;
                    $display("FAIL accept_unexpected: cyc=%0d count=%0d", mcyc, trig_count);
                end else begin
                    acc_t a;
                    a = acc_q.pop_front();
                    if ((a.cyc != mcyc) || (a.tc != int'(trig_count))) begin
                        bad++;
                        $display("FAIL accept: got cyc=%0d count=%0d want cyc=%0d count=%0d",
                                 mcyc, trig_count, a.cyc, a.tc);
                    end
                end
            end
            mcyc++;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_accept"}, int'(trig_accept), 0);
        check({tag, "_busy"},   int'(trig_busy), 1);
        check({tag, "_tcount"}, int'(trig_count), 0);
        check({tag, "_vcount"}, int'(veto_count), 0);
        check({tag, "_tflag"},  int'(timeout_flag), 0);
    endtask

    task automatic release_reset();
        status_q.delete();
        acc_q.delete();
        reset = 1'b0;
        model_reset();
        mcyc   = 0;
        mon_en = 1'b1;
    endtask

    // Asynchronous reset landing mid-cycle; outputs must drop to reset values without a clock.
    task automatic mid_reset();
        #2;
        reset  = 1'b1;
        mon_en = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(posedge clk);
        #1;
        release_reset();
    endtask

    task automatic drive_cycle(input int p_ack);
        run_enable = ($urandom_range(0, 149) != 0);
        cnt_clear  = ($urandom_range(0, 599) == 0);
        daq_ack    = ($urandom_range(0, 99) < p_ack);
        if ($urandom_range(0, 4) == 0) begin
            case ($urandom_range(0, 2))
                0:       chan_trig = '0;
                1:       chan_trig = coinc_mask | N_CHAN'($urandom);
                default: chan_trig = N_CHAN'($urandom);
            endcase
        end
        if ($urandom_range(0, 39) == 0) deadtime = 16'($urandom_range(0, 12));
    endtask

    task automatic step(input int p_ack);
        drive_cycle(p_ack);
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p_ack;
        bit rst_done;
        reset      = 1'b1;
        run_enable = 1'b0;
        cnt_clear  = 1'b0;
        chan_trig  = '0;
        coinc_mask = '0;
        coinc_and  = 1'b0;
        prescale   = '0;
        deadtime   = '0;
        daq_ack    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        release_reset();

        for (int seg = 0; seg < 24; seg++) begin
            coinc_mask = ($urandom_range(0, 7) == 0) ? '0 : N_CHAN'($urandom);
            coinc_and  = 1'($urandom_range(0, 1));
            prescale   = 16'($urandom_range(0, 3));
            deadtime   = 16'($urandom_range(0, 12));
            case ($urandom_range(0, 3))
                0:       p_ack = 0;
                1:       p_ack = 20;
                2:       p_ack = 60;
                default: p_ack = 100;
            endcase
            // One disabled cycle so the new prescale starts from a fresh count.
            run_enable = 1'b0;
            cnt_clear  = 1'b0;
            daq_ack    = 1'b0;
            model_step();
            @(posedge clk);
            #1;
            rst_done = 1'b0;
            for (int k = 0; k < 200; k++) begin
                step(p_ack);
                if (!rst_done && (seg % 6 == 5) && m_wait && (mc > m_wstart)) begin
                    mid_reset();
                    rst_done = 1'b1;
                end
            end
        end

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("accept_queue_drained", acc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
